// File: rtl/wb_burst_master_if.sv
// Command, write/read data streams and Wishbone master bus of wb_burst_master.
// clk and reset stay outside as plain ports.
interface wb_burst_master_if #(
  parameter int unsigned aw = 32,
  parameter int unsigned dw = 32
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_we_i;
  logic [aw-1:0]     cmd_adr_i;
  logic [dw/8-1:0]   cmd_sel_i;
  logic [3:0]        cmd_len_i;
  logic [1:0]        cmd_bte_i;

  logic [dw-1:0]     wdat_i;
  logic              wdat_valid_i;
  logic              wdat_ready_o;
  logic [dw-1:0]     rdat_o;
  logic              rdat_valid_o;
  logic              done_o;
  logic              err_o;

  logic [aw-1:0]     wb_adr_o;
  logic [dw-1:0]     wb_dat_o;
  logic [dw/8-1:0]   wb_sel_o;
  logic              wb_we_o;
  logic [2:0]        wb_cti_o;
  logic [1:0]        wb_bte_o;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic [dw-1:0]     wb_dat_i;
  logic              wb_ack_i;
  logic              wb_err_i;
  logic              wb_rty_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_len_i, cmd_bte_i,
    input  wdat_i, wdat_valid_i, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    output cmd_ready_o, wdat_ready_o, rdat_o, rdat_valid_o, done_o, err_o,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cti_o, wb_bte_o, wb_cyc_o, wb_stb_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_len_i, cmd_bte_i,
    output wdat_i, wdat_valid_i, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    input  cmd_ready_o, wdat_ready_o, rdat_o, rdat_valid_o, done_o, err_o,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cti_o, wb_bte_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B4 registered-feedback burst master: one command of up to 16 beats,
// linear or wrapping addressing, err/rty/timeout abort, one-cycle done pulse.
module wb_burst_master #(
  parameter int unsigned aw      = 32,
  parameter int unsigned dw      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  wb_burst_master_if.master bus
);
  localparam int unsigned sw = dw / 8;
  localparam int unsigned tw = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WFILL = 2'd1;
  localparam logic [1:0] BUS   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d, wdat_ready_q, wdat_ready_d;
  logic [dw-1:0] rdat_q, rdat_d, dat_q, dat_d;
  logic          rdat_valid_q, rdat_valid_d, done_q, done_d, err_q, err_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [sw-1:0] sel_q, sel_d;
  logic          we_q, we_d, cyc_q, cyc_d, stb_q, stb_d, eflag_q, eflag_d;
  logic [2:0]    cti_q, cti_d;
  logic [1:0]    bte_q, bte_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [tw-1:0] tcnt_q, tcnt_d;
  logic          fail, ack, tout;

  // Next beat address: linear, or wrap inside a 4/8/16-beat aligned block.
  function automatic logic [aw-1:0] next_adr(input logic [aw-1:0] a, input logic [1:0] bte);
    logic [aw-1:0] inc, mask;
    inc = a + aw'(sw);
    case (bte)
      2'b01:   mask = aw'(sw * 4 - 1);
      2'b10:   mask = aw'(sw * 8 - 1);
      2'b11:   mask = aw'(sw * 16 - 1);
      default: mask = '1;
    endcase
    return (a & ~mask) | (inc & mask);
  endfunction

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    wdat_ready_d = wdat_ready_q;
    rdat_d       = rdat_q;
    rdat_valid_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    we_d         = we_q;
    cti_d        = cti_q;
    bte_d        = bte_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    cnt_d        = cnt_q;
    tcnt_d       = tcnt_q;
    eflag_d      = eflag_q;
    // err/rty outrank ack; ack outranks the timeout on the same cycle
    fail = stb_q & (bus.wb_err_i | bus.wb_rty_i);
    ack  = stb_q & bus.wb_ack_i & ~fail;
    tout = stb_q & ~bus.wb_ack_i & ~fail & (tcnt_q == tw'(TIMEOUT - 1));

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          we_d        = bus.cmd_we_i;
          adr_d       = bus.cmd_adr_i;
          sel_d       = bus.cmd_sel_i;
          bte_d       = bus.cmd_bte_i;
          cnt_d       = bus.cmd_len_i;
          cti_d       = (bus.cmd_len_i == 4'd0) ? 3'b000 : 3'b010;
          tcnt_d      = '0;
          eflag_d     = 1'b0;
          if (bus.cmd_we_i) begin
            wdat_ready_d = 1'b1;
            state_d      = WFILL;
          end else begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            state_d = BUS;
          end
        end
      end
      WFILL: begin
        if (bus.wdat_valid_i) begin
          dat_d        = bus.wdat_i;
          wdat_ready_d = 1'b0;
          cyc_d        = 1'b1;
          stb_d        = 1'b1;
          tcnt_d       = '0;
          state_d      = BUS;
        end
      end
      BUS: begin
        if (fail || tout) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          eflag_d = 1'b1;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (ack) begin
          if (!we_q) begin
            rdat_d       = bus.wb_dat_i;
            rdat_valid_d = 1'b1;
          end
          if (cnt_q == 4'd0) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            done_d  = 1'b1;
            err_d   = eflag_q;
            state_d = DONE;
          end else begin
            adr_d  = next_adr(adr_q, bte_q);
            cnt_d  = cnt_q - 4'd1;
            cti_d  = (cnt_q == 4'd1) ? 3'b111 : 3'b010;
            tcnt_d = '0;
            if (we_q) begin
              stb_d        = 1'b0;
              wdat_ready_d = 1'b1;
              state_d      = WFILL;
            end
          end
        end else if (stb_q) begin
          tcnt_d = tcnt_q + tw'(1);
        end
      end
      default: begin
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;       cmd_ready_q <= 1'b1;  wdat_ready_q <= 1'b0;
      rdat_q <= '0;          dat_q <= '0;          rdat_valid_q <= 1'b0;
      done_q <= 1'b0;        err_q <= 1'b0;        adr_q <= '0;
      sel_q <= '0;           we_q <= 1'b0;         cyc_q <= 1'b0;
      stb_q <= 1'b0;         eflag_q <= 1'b0;      cti_q <= 3'b000;
      bte_q <= 2'b00;        cnt_q <= '0;          tcnt_q <= '0;
    end else begin
      state_q <= state_d;    cmd_ready_q <= cmd_ready_d;  wdat_ready_q <= wdat_ready_d;
      rdat_q <= rdat_d;      dat_q <= dat_d;       rdat_valid_q <= rdat_valid_d;
      done_q <= done_d;      err_q <= err_d;       adr_q <= adr_d;
      sel_q <= sel_d;        we_q <= we_d;         cyc_q <= cyc_d;
      stb_q <= stb_d;        eflag_q <= eflag_d;   cti_q <= cti_d;
      bte_q <= bte_d;        cnt_q <= cnt_d;       tcnt_q <= tcnt_d;
    end
  end

  assign bus.cmd_ready_o  = cmd_ready_q;
  assign bus.wdat_ready_o = wdat_ready_q;
  assign bus.rdat_o       = rdat_q;
  assign bus.rdat_valid_o = rdat_valid_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;
  assign bus.wb_adr_o     = adr_q;
  assign bus.wb_dat_o     = dat_q;
  assign bus.wb_sel_o     = sel_q;
  assign bus.wb_we_o      = we_q;
  assign bus.wb_cti_o     = cti_q;
  assign bus.wb_bte_o     = bte_q;
  assign bus.wb_cyc_o     = cyc_q;
  assign bus.wb_stb_o     = stb_q;
endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: directed vector table, mid-burst reset and
// randomized commands against a beat-level model of the addressing/termination rules.
module tb_wb_burst_master;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_burst_master_if #(.aw(32), .dw(32)) bus();
  wb_burst_master #(.aw(32), .dw(32), .TIMEOUT(8)) dut (.wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(bus));

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [3:0]  sel;
    int          len;
    logic [1:0]  bte;
    int          dly;
    int          err_beat;
    bit          rty;
    int          stall_beat;
    int          stall_cyc;
    bit          hang;
    bit          exp_err;
    int          exp_rd;
    logic [31:0] exp_last;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [31:0] rdata [16];
  logic [31:0] wdata [16];
  int          ack_dly [16];
  bit          c_we, c_rty, c_hang, c_noise;
  logic [31:0] c_adr;
  logic [3:0]  c_sel;
  logic [1:0]  c_bte;
  int          c_len, c_err_beat, c_stall_beat, c_stall_cyc, c_rst_beat;
  bit          obs_err;
  int          obs_rd;
  logic [31:0] obs_last;
  vec_t        tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Address of beat i from start address, purely by block arithmetic.
  function automatic logic [31:0] exp_adr(input logic [31:0] a, input logic [1:0] bte, input int i);
    logic [31:0] blk;
    if (bte == 2'd0) return a + 32'(4 * i);
    blk = 32'd8 << bte;
    return a - (a % blk) + (((a % blk) + 32'(4 * i)) % blk);
  endfunction

  task automatic clear_inputs();
    bus.cmd_valid_i = 1'b0; bus.cmd_we_i = 1'b0; bus.cmd_adr_i = '0; bus.cmd_sel_i = '0;
    bus.cmd_len_i = '0; bus.cmd_bte_i = '0; bus.wdat_i = '0; bus.wdat_valid_i = 1'b0;
    bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
  endtask

  task automatic run_cmd();
    int  b, wt, rcnt, wbeat, stall, stbcyc, n_exp, e_rd;
    bit  fin, e_err;
    logic [2:0] e_cti;
    if (c_hang) begin n_exp = 0; e_err = 1'b1; end
    else if (c_err_beat >= 0 && c_err_beat <= c_len) begin n_exp = c_err_beat; e_err = 1'b1; end
    else begin n_exp = c_len + 1; e_err = 1'b0; end
    e_rd = c_we ? 0 : n_exp;
    for (int i = 0; i < 16; i++) begin rdata[i] = $urandom; wdata[i] = $urandom; end
    b = 0; wt = 0; rcnt = 0; wbeat = 0; stall = c_stall_cyc; stbcyc = 0; fin = 1'b0;
    obs_err = 1'b0; obs_last = c_adr;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(bus.cmd_ready_o), 32'd1);
    bus.cmd_valid_i = 1'b1; bus.cmd_we_i = c_we; bus.cmd_adr_i = c_adr; bus.cmd_sel_i = c_sel;
    bus.cmd_len_i = 4'(c_len); bus.cmd_bte_i = c_bte;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (bus.rdat_valid_o) begin
        chk("rdat", bus.rdat_o, rdata[rcnt & 15]);
        rcnt++;
      end
      chk("ready_excl", 32'(bus.cmd_ready_o & bus.wdat_ready_o), 32'd0);
      bus.wdat_valid_i = 1'b0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
      if (bus.done_o) begin
        obs_err = bus.err_o;
        chk("err_o", 32'(bus.err_o), 32'(e_err));
        chk("beats_acked", 32'(b), 32'(n_exp));
        chk("rdat_count", 32'(rcnt), 32'(e_rd));
        chk("cyc_stb_dropped", 32'({bus.wb_cyc_o, bus.wb_stb_o}), 32'd0);
        fin = 1'b1;
      end else begin
        if (bus.wdat_ready_o) begin
          if (wbeat == c_stall_beat && stall > 0) stall--;
          else begin bus.wdat_valid_i = 1'b1; bus.wdat_i = wdata[wbeat & 15]; wbeat++; end
        end
        if (bus.wb_stb_o) begin
          if (wt == 0) begin
            e_cti = (c_len == 0) ? 3'b000 : ((b == c_len) ? 3'b111 : 3'b010);
            obs_last = bus.wb_adr_o;
            chk("adr", bus.wb_adr_o, exp_adr(c_adr, c_bte, b));
            chk("cti", 32'(bus.wb_cti_o), 32'(e_cti));
            chk("we_sel_bte", 32'({bus.wb_we_o, bus.wb_sel_o, bus.wb_bte_o}), 32'({c_we, c_sel, c_bte}));
            chk("cyc_with_stb", 32'(bus.wb_cyc_o), 32'd1);
            if (c_we) chk("wb_dat_o", bus.wb_dat_o, wdata[b & 15]);
            if (c_rst_beat == b) begin
              rst_n = 1'b0;
              #1;
              chk("rst_async_cyc_stb", 32'({bus.wb_cyc_o, bus.wb_stb_o}), 32'd0);
              chk("rst_outs", 32'({bus.done_o, bus.err_o, bus.rdat_valid_o, bus.wb_we_o, bus.wb_cti_o}), 32'd0);
              @(negedge clk);
              chk("rst_no_done", 32'(bus.done_o), 32'd0);
              rst_n = 1'b1;
              @(negedge clk);
              chk("rst_release_ready", 32'(bus.cmd_ready_o), 32'd1);
              chk("rst_release_done", 32'(bus.done_o), 32'd0);
              return;
            end
          end
          stbcyc++;
          if (!c_hang && wt == ack_dly[b & 15]) begin
            if (b == c_err_beat) begin
              if (c_rty) bus.wb_rty_i = 1'b1; else bus.wb_err_i = 1'b1;
              bus.wb_ack_i = 1'($urandom_range(0, 1));
            end else begin
              bus.wb_ack_i = 1'b1; bus.wb_dat_i = rdata[b & 15]; b++;
            end
            wt = 0;
          end else wt++;
        end else begin
          if (c_we && b > 0) chk("cyc_hold_wait", 32'(bus.wb_cyc_o), 32'd1);
          if (c_noise) begin
            bus.wb_ack_i = 1'($urandom_range(0, 1)); bus.wb_err_i = 1'($urandom_range(0, 1));
            bus.wb_rty_i = 1'($urandom_range(0, 1));
          end
        end
        @(negedge clk);
      end
    end
    chk("done_seen", 32'(fin), 32'd1);
    if (c_hang) chk("timeout_stb_cycles", 32'(stbcyc), 32'd8);
    obs_rd = rcnt;
    clear_inputs();
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done_o), 32'd0);
    chk("ready_after_done", 32'(bus.cmd_ready_o), 32'd1);
  endtask

  task automatic apply_vec(input vec_t v);
    c_we = v.we; c_adr = v.adr; c_sel = v.sel; c_len = v.len; c_bte = v.bte;
    c_err_beat = v.err_beat; c_rty = v.rty; c_stall_beat = v.stall_beat;
    c_stall_cyc = v.stall_cyc; c_hang = v.hang; c_noise = 1'b0; c_rst_beat = -1;
    for (int i = 0; i < 16; i++) ack_dly[i] = v.dly;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            we    adr        sel   len bte  dly err rty   stall  hang  e_err rd  last
    tbl[0] = '{1'b0, 32'h100,  4'hF, 0,  2'd0, 2, -1, 1'b0, -1, 0, 1'b0, 1'b0, 1,  32'h100};
    tbl[1] = '{1'b1, 32'h1F8,  4'hF, 3,  2'd1, 1, -1, 1'b0,  2, 2, 1'b0, 1'b0, 0,  32'h1F4};
    tbl[2] = '{1'b0, 32'h0,    4'hF, 7,  2'd0, 0,  3, 1'b0, -1, 0, 1'b0, 1'b1, 3,  32'h0C};
    tbl[3] = '{1'b0, 32'h40,   4'hF, 2,  2'd0, 0, -1, 1'b0, -1, 0, 1'b1, 1'b1, 0,  32'h40};
    tbl[4] = '{1'b0, 32'h2C,   4'h3, 7,  2'd2, 1, -1, 1'b0, -1, 0, 1'b0, 1'b0, 8,  32'h28};
    tbl[5] = '{1'b1, 32'h1004, 4'hC, 15, 2'd3, 0, -1, 1'b0,  5, 1, 1'b0, 1'b0, 0,  32'h1000};
    tbl[6] = '{1'b1, 32'h200,  4'h1, 0,  2'd0, 1,  0, 1'b1, -1, 0, 1'b0, 1'b1, 0,  32'h200};
    tbl[7] = '{1'b0, 32'h300,  4'hF, 15, 2'd0, 6, -1, 1'b0, -1, 0, 1'b0, 1'b0, 16, 32'h33C};
    clear_inputs();
    rst_n = 1'b0;
    #2;
    chk("reset_cyc_stb", 32'({bus.wb_cyc_o, bus.wb_stb_o}), 32'd0);
    chk("reset_outs", 32'({bus.done_o, bus.err_o, bus.rdat_valid_o, bus.wb_we_o, bus.wb_cti_o}), 32'd0);
    chk("reset_wdat_ready", 32'(bus.wdat_ready_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.cmd_ready_o), 32'd1);

    for (int t = 0; t < 8; t++) begin
      apply_vec(tbl[t]);
      run_cmd();
      chk($sformatf("tbl%0d_err", t), 32'(obs_err), 32'(tbl[t].exp_err));
      chk($sformatf("tbl%0d_rd", t), 32'(obs_rd), 32'(tbl[t].exp_rd));
      chk($sformatf("tbl%0d_last_adr", t), obs_last, tbl[t].exp_last);
    end

    // reset during beat 2 of a read burst, then a normal command
    apply_vec('{1'b0, 32'h80, 4'hF, 7, 2'd0, 1, -1, 1'b0, -1, 0, 1'b0, 1'b0, 0, 32'h0});
    c_rst_beat = 2;
    run_cmd();
    clear_inputs();
    apply_vec('{1'b0, 32'h500, 4'hF, 1, 2'd0, 1, -1, 1'b0, -1, 0, 1'b0, 1'b0, 2, 32'h504});
    run_cmd();
    chk("post_rst_err", 32'(obs_err), 32'd0);
    chk("post_rst_rd", 32'(obs_rd), 32'd2);

    for (int r = 0; r < 40; r++) begin
      c_we = 1'($urandom_range(0, 1));
      c_adr = $urandom & 32'hFFFF_FFFC;
      c_sel = 4'($urandom_range(0, 15));
      c_len = $urandom_range(0, 15);
      c_bte = 2'($urandom_range(0, 3));
      c_err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, c_len)) : -1;
      c_rty = 1'($urandom_range(0, 1));
      c_hang = ($urandom_range(0, 9) == 0);
      c_noise = 1'($urandom_range(0, 1));
      c_stall_beat = $urandom_range(0, c_len);
      c_stall_cyc = $urandom_range(0, 3);
      c_rst_beat = -1;
      for (int i = 0; i < 16; i++) ack_dly[i] = $urandom_range(0, 6);
      run_cmd();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter aw, default 32, Wishbone address width.
REQ-002 SHALL have parameter dw, default 32, data width; sel width is dw/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles a beat waits for a termination before abort.
REQ-004 SHALL have wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have wb_rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have cmd_valid_i in 1, cmd_ready_o out 1  command handshake.
REQ-007 SHALL have cmd_we_i in 1, cmd_adr_i in aw, cmd_sel_i in dw/8, cmd_len_i in 4 (beats-1), cmd_bte_i in 2  command fields.
REQ-008 SHALL have wdat_i in dw, wdat_valid_i in 1, wdat_ready_o out 1  write-data stream.
REQ-009 SHALL have rdat_o out dw, rdat_valid_o out 1  read-data stream, no backpressure.
REQ-010 SHALL have done_o out 1, err_o out 1  one-cycle completion pulse; err_o qualifies done_o.
REQ-011 SHALL have wb_adr_o aw, wb_dat_o dw, wb_sel_o dw/8, wb_we_o 1, wb_cti_o 3, wb_bte_o 2, wb_cyc_o 1, wb_stb_o 1  outputs to slave.
REQ-012 SHALL have wb_dat_i dw, wb_ack_i 1, wb_err_i 1, wb_rty_i 1  inputs from slave.

Function
REQ-013 SHALL implement states IDLE, WFILL, BUS, DONE.
REQ-014 IDLE: cmd_ready_o=1; cmd_valid_i&cmd_ready_o latches all cmd fields, beat counter=cmd_len_i; goes to WFILL if write, else BUS.
REQ-015 WFILL: wdat_ready_o=1, cyc/stb held at current value; accepted word goes to wb_dat_o next cycle with stb=1, state BUS.
REQ-016 BUS: wb_cyc_o=wb_stb_o=1; wb_we_o, wb_sel_o, wb_bte_o constant for the whole command.
REQ-017 wb_cti_o SHALL be 000 for single beat (len=0); for bursts 010 on every beat except last, 111 on last beat.
REQ-018 On wb_ack_i in BUS: read beat drives rdat_o=wb_dat_i with rdat_valid_o=1 same-cycle-registered (next cycle, one-cycle pulse).
REQ-019 On ack, non-last beat: address advances; write -> back to WFILL with stb=0 and cyc=1 kept (wait state); read -> stays BUS.
REQ-020 Address advance SHALL be +dw/8 for bte=00; bte 01/10/11 wraps within 4/8/16-beat aligned block (upper bits frozen).
REQ-021 On ack of last beat: cyc and stb drop next cycle, state DONE.
REQ-022 DONE: done_o=1 for exactly one cycle, err_o=sticky error flag, then IDLE.
REQ-023 wb_err_i or wb_rty_i while stb=1 SHALL terminate the command: cyc/stb drop next cycle, error flag set, DONE; remaining beats discarded, no rdat_valid_o for that beat.
REQ-024 Timeout counter SHALL reset on every beat start and count cycles with stb=1 and no termination; at TIMEOUT: abort as REQ-023.
REQ-025 Simultaneous ack and err SHALL be treated as err.
REQ-026 Terminations while stb=0 SHALL be ignored.
REQ-027 cmd_ready_o and wdat_ready_o SHALL never be high together; both low outside IDLE/WFILL.

Reset
REQ-028 wb_rst_ni low SHALL immediately force IDLE, wb_cyc_o=wb_stb_o=0, done_o=err_o=rdat_valid_o=0, wb_cti_o=000, wb_we_o=0, counters 0, regardless of bus state.
REQ-029 Reset mid-burst SHALL abandon the command with no done_o pulse; after release, cmd_ready_o=1 on the first clock.

Verification
REQ-030 Single read adr 0x100, len 0, slave acks after 2 cycles -> cti 000, one rdat_valid_o with slave data, done_o=1 err_o=0.
REQ-031 Write burst adr 0x1F8, len 3, bte 01, wdat stalls 2 cycles before beat 2 -> adr 0x1F8,0x1FC,0x1F0,0x1F4; cti 010,010,010,111; stb low during stall, cyc high.
REQ-032 Read burst len 7 bte 00, wb_err_i on beat 3 -> exactly 3 rdat_valid_o, cyc low next cycle, done_o=1 err_o=1.
REQ-033 Slave never terminates, TIMEOUT=8 -> stb high 8 cycles, then abort, done_o=1 err_o=1, cmd_ready_o=1 afterwards.
REQ-034 wb_rst_ni asserted mid read burst beat 2 -> cyc/stb low asynchronously, no done_o; next command completes normally.
